// File: rtl/wb_trace_fifo_pkg.sv
// Shared trace-entry layout and kind codes for the commit-trace FIFO.
// One entry is {kind, pc, addr, data} = 97 bits.
package wb_trace_fifo_pkg;

    localparam logic KIND_GRF = 1'b0;
    localparam logic KIND_DM  = 1'b1;

    localparam int PC_W    = 32;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int ENTRY_W = 1 + PC_W + ADDR_W + DATA_W;

    typedef struct packed {
        logic              kind;
        logic [PC_W-1:0]   pc;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } trace_entry_t;

endpackage

// File: rtl/wb_trace_fifo_if.sv
// Capture/drain bundle for the commit-trace FIFO.
// The slave side is the FIFO; the master side is the core plus the trace consumer.
interface wb_trace_fifo_if #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             clear;
    logic [31:0]      pc;
    logic             grf_we;
    logic [4:0]       grf_addr;
    logic [31:0]      grf_wdata;
    logic             dm_we;
    logic [31:0]      dm_addr;
    logic [31:0]      dm_wdata;
    logic             out_valid;
    logic             out_ready;
    logic             out_kind;
    logic [31:0]      out_pc;
    logic [31:0]      out_addr;
    logic [31:0]      out_data;
    logic [CW-1:0]    count;
    logic             overflow;
    logic [CNT_W-1:0] drop_cnt;

    modport master (
        output clear, pc, grf_we, grf_addr, grf_wdata, dm_we, dm_addr, dm_wdata, out_ready,
        input  out_valid, out_kind, out_pc, out_addr, out_data, count, overflow, drop_cnt
    );

    modport slave (
        input  clear, pc, grf_we, grf_addr, grf_wdata, dm_we, dm_addr, dm_wdata, out_ready,
        output out_valid, out_kind, out_pc, out_addr, out_data, count, overflow, drop_cnt
    );

endinterface

// File: rtl/wb_trace_fifo_store.sv
// Entry storage: DEPTH x trace_entry_t, two write ports, one asynchronous read port.
// Contents are never reset; validity is tracked by the owner's pointers.
module wb_trace_fifo_store
    import wb_trace_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         we0,
    input  logic [AW-1:0] wa0,
    input  trace_entry_t wd0,
    input  logic         we1,
    input  logic [AW-1:0] wa1,
    input  trace_entry_t wd1,
    input  logic [AW-1:0] ra,
    output trace_entry_t rd
);

    trace_entry_t mem_q [DEPTH];

    // The owner never enables both ports onto the same slot.
    always_ff @(posedge clk) begin
        if (we0) mem_q[wa0] <= wd0;
        if (we1) mem_q[wa1] <= wd1;
    end

    assign rd = mem_q[ra];

endmodule

// File: rtl/wb_trace_fifo.sv
// Commit-trace FIFO: captures GRF writes and DM stores with their PC, drains one per
// handshake, and counts (saturating) every event rejected for lack of space.
module wb_trace_fifo
    import wb_trace_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input logic            clk,
    input logic            reset,
    wb_trace_fifo_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic             ev_g, ev_d, pop, acc_g, acc_d;
    logic [CW:0]      free;
    logic [1:0]       n_drop;
    logic [CNT_W:0]   drop_sum;
    logic             we0, we1;
    logic [AW-1:0]    wa1;
    trace_entry_t     wd0, wd1, head;

    always_comb begin
        ev_g = bus.grf_we && (bus.grf_addr != 5'd0);
        ev_d = bus.dm_we;
        pop  = (count_q != '0) && bus.out_ready;

        // A same-cycle pop frees a slot the pushes may use.
        free  = (CW+1)'(DEPTH) - {1'b0, count_q} + (CW+1)'(pop);
        acc_g = ev_g && (free != '0);
        acc_d = ev_d && (free > (CW+1)'(acc_g));

        n_drop   = 2'(ev_g && !acc_g) + 2'(ev_d && !acc_d);
        drop_sum = {1'b0, drop_cnt_q} + (CNT_W+1)'(n_drop);

        wd0.kind = KIND_GRF;
        wd0.pc   = bus.pc;
        wd0.addr = {27'b0, bus.grf_addr};
        wd0.data = bus.grf_wdata;
        wd1.kind = KIND_DM;
        wd1.pc   = bus.pc;
        wd1.addr = bus.dm_addr;
        wd1.data = bus.dm_wdata;

        we0 = acc_g && !bus.clear;
        we1 = acc_d && !bus.clear;
        wa1 = wr_ptr_q + AW'(acc_g);

        wr_ptr_d   = wr_ptr_q + AW'(acc_g) + AW'(acc_d);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        count_d    = count_q + CW'(acc_g) + CW'(acc_d) - CW'(pop);
        overflow_d = overflow_q || (n_drop != 2'd0);
        drop_cnt_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];

        // Flush wins over everything; that cycle's events are neither stored nor counted.
        if (bus.clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    wb_trace_fifo_store #(.DEPTH(DEPTH)) u_store (
        .clk (clk),
        .we0 (we0),
        .wa0 (wr_ptr_q),
        .wd0 (wd0),
        .we1 (we1),
        .wa1 (wa1),
        .wd1 (wd1),
        .ra  (rd_ptr_q),
        .rd  (head)
    );

    assign bus.out_valid = (count_q != '0);
    assign bus.out_kind  = bus.out_valid ? head.kind : 1'b0;
    assign bus.out_pc    = bus.out_valid ? head.pc   : '0;
    assign bus.out_addr  = bus.out_valid ? head.addr : '0;
    assign bus.out_data  = bus.out_valid ? head.data : '0;
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;
    assign bus.drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Directed bench for wb_trace_fifo: a queue model checked every negedge plus literal spot checks.
module tb_wb_trace_fifo;
    import wb_trace_fifo_pkg::*;

    localparam int DEPTH = 16;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    wb_trace_fifo_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    wb_trace_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a queue of entries, a sticky flag and a saturating drop count.
    trace_entry_t mq[$];
    bit           m_ovf;
    int           m_drop;
    int           space;
    trace_entry_t e;

    task automatic model_drop();
        m_ovf = 1'b1;
        if (m_drop < (1 << CNT_W) - 1) m_drop++;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || bus.clear) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_drop = 0;
        end else begin
            if (mq.size() != 0 && bus.out_ready) void'(mq.pop_front());
            space = DEPTH - mq.size();
            if (bus.grf_we && bus.grf_addr != 5'd0) begin
                if (space > 0) begin
                    e = '{kind: 1'b0, pc: bus.pc, addr: {27'b0, bus.grf_addr}, data: bus.grf_wdata};
                    mq.push_back(e);
                    space--;
                end else model_drop();
            end
            if (bus.dm_we) begin
                if (space > 0) begin
                    e = '{kind: 1'b1, pc: bus.pc, addr: bus.dm_addr, data: bus.dm_wdata};
                    mq.push_back(e);
                    space--;
                end else model_drop();
            end
        end
    end

    always @(negedge clk) begin
        trace_entry_t h;
        bit v;
        v = (mq.size() != 0);
        h = v ? mq[0] : '0;
        chk("cyc_valid", 32'(bus.out_valid), 32'(v));
        chk("cyc_kind",  32'(bus.out_kind),  32'(h.kind));
        chk("cyc_pc",    bus.out_pc,   h.pc);
        chk("cyc_addr",  bus.out_addr, h.addr);
        chk("cyc_data",  bus.out_data, h.data);
        chk("cyc_count", 32'(bus.count), 32'(mq.size()));
        chk("cyc_ovf",   32'(bus.overflow), 32'(m_ovf));
        chk("cyc_drop",  32'(bus.drop_cnt), 32'(m_drop));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.grf_we = 1'b0;
        bus.dm_we  = 1'b0;
        bus.clear  = 1'b0;
    endtask

    task automatic set_grf(input logic [31:0] p, input logic [4:0] a, input logic [31:0] d);
        bus.pc = p; bus.grf_we = 1'b1; bus.grf_addr = a; bus.grf_wdata = d;
    endtask

    task automatic set_dm(input logic [31:0] a, input logic [31:0] d);
        bus.dm_we = 1'b1; bus.dm_addr = a; bus.dm_wdata = d;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.clear = 1'b0; bus.pc = '0; bus.grf_we = 1'b1; bus.grf_addr = 5'd5;
        bus.grf_wdata = 32'hdead; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
        bus.out_ready = 1'b0;

        // 1: reset held with an active GRF write
        repeat (2) cyc();
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_data",  bus.out_data, 32'd0);
        chk("rst_ovf",   32'(bus.overflow), 32'd0);
        idle();
        rst_n = 1'b1;
        cyc();
        $display("reset released, count=%0d", bus.count);

        // 2: single GRF, then a $0 write that must be ignored
        set_grf(32'h3000, 5'd8, 32'h1234);
        cyc();
        chk("g1_valid", 32'(bus.out_valid), 32'd1);
        chk("g1_kind",  32'(bus.out_kind), 32'd0);
        chk("g1_addr",  bus.out_addr, 32'd8);
        chk("g1_data",  bus.out_data, 32'h1234);
        chk("g1_count", 32'(bus.count), 32'd1);
        set_grf(32'h3004, 5'd0, 32'h99);
        cyc();
        chk("g0_count", 32'(bus.count), 32'd1);
        chk("g0_addr",  bus.out_addr, 32'd8);
        $display("single GRF: count=%0d addr=0x%0h", bus.count, bus.out_addr);
        idle();
        bus.out_ready = 1'b1;
        cyc();
        bus.out_ready = 1'b0;

        // 3: dual push in one cycle, GRF first
        set_grf(32'h3008, 5'd2, 32'd5);
        set_dm(32'h10, 32'd7);
        cyc();
        idle();
        chk("dual_count", 32'(bus.count), 32'd2);
        chk("dual_kind",  32'(bus.out_kind), 32'd0);
        chk("dual_addr",  bus.out_addr, 32'd2);
        bus.out_ready = 1'b1;
        cyc();
        bus.out_ready = 1'b0;
        chk("pop_kind",  32'(bus.out_kind), 32'd1);
        chk("pop_addr",  bus.out_addr, 32'h10);
        chk("pop_data",  bus.out_data, 32'd7);
        chk("pop_count", 32'(bus.count), 32'd1);
        $display("dual push/pop: head kind=%0d addr=0x%0h", bus.out_kind, bus.out_addr);
        bus.out_ready = 1'b1;
        cyc();
        bus.out_ready = 1'b0;

        // 4: fill to DEPTH-1, then dual push overflows by one
        for (int i = 0; i < DEPTH - 1; i++) begin
            set_grf(32'h4000 + 32'(4 * i), 5'(i % 31 + 1), 32'h100 + 32'(i));
            cyc();
        end
        set_grf(32'h5000, 5'd3, 32'haaa);
        set_dm(32'h20, 32'hbbb);
        cyc();
        idle();
        chk("ovf_count", 32'(bus.count), 32'(DEPTH));
        chk("ovf_flag",  32'(bus.overflow), 32'd1);
        chk("ovf_drop1", 32'(bus.drop_cnt), 32'd1);
        set_grf(32'h5004, 5'd4, 32'hccc);
        cyc();
        idle();
        chk("ovf_drop2", 32'(bus.drop_cnt), 32'd2);
        $display("overflow: count=%0d drop_cnt=%0d", bus.count, bus.drop_cnt);

        // 5: full with simultaneous pop and push
        bus.out_ready = 1'b1;
        set_grf(32'h6000, 5'd6, 32'hddd);
        cyc();
        idle();
        chk("full_count", 32'(bus.count), 32'(DEPTH));
        chk("full_drop",  32'(bus.drop_cnt), 32'd2);
        repeat (3) cyc();
        bus.out_ready = 1'b0;
        $display("full pop+push: count=%0d", bus.count);

        // 6: clear with a dual push in the same cycle
        bus.clear = 1'b1;
        set_grf(32'h7000, 5'd7, 32'h1);
        set_dm(32'h30, 32'h2);
        cyc();
        idle();
        chk("clr_count", 32'(bus.count), 32'd0);
        chk("clr_drop",  32'(bus.drop_cnt), 32'd0);
        chk("clr_ovf",   32'(bus.overflow), 32'd0);
        chk("clr_valid", 32'(bus.out_valid), 32'd0);
        $display("clear: count=%0d drop_cnt=%0d", bus.count, bus.drop_cnt);

        for (int i = 0; i < 3; i++) begin
            set_grf(32'h8000 + 32'(4 * i), 5'(10 + i), 32'h500 + 32'(i));
            cyc();
        end
        idle();
        chk("refill_count", 32'(bus.count), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_count", 32'(bus.count), 32'd0);
        chk("arst_data",  bus.out_data, 32'd0);
        #2 rst_n = 1'b1;
        $display("async reset mid-drain: valid=%0d", bus.out_valid);
        cyc();
        set_grf(32'h9000, 5'd9, 32'habc);
        cyc();
        idle();
        chk("post_valid", 32'(bus.out_valid), 32'd1);
        chk("post_addr",  bus.out_addr, 32'd9);
        chk("post_pc",    bus.out_pc, 32'h9000);
        chk("post_count", 32'(bus.count), 32'd1);
        $display("after reset: head addr=0x%0h data=0x%0h", bus.out_addr, bus.out_data);
        repeat (2) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
